// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states
// and a small magnitude helper used when preparing signed divides.
package md_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } md_state_t;

    // 0x80000000 maps to itself, which reads correctly as an unsigned magnitude
    function automatic logic [31:0] mag32(input logic [31:0] v,
                                          input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_divider.sv
// Unsigned 32/32 restoring divider: one quotient bit per cycle, MSB first.
// done pulses for one cycle once all 32 iterations have completed.
module md_divider
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;
    logic [5:0]  r_cnt;
    logic        r_active;
    logic        r_done;

    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;

    // Shifted partial remainder can exceed 32 bits before the subtract
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_quo    <= dividend;
                r_rem    <= '0;
                r_dvs    <= divisor;
                r_cnt    <= 6'd32;
                r_active <= 1'b1;
            end else if (r_active) begin
                if (!w_diff[32]) begin
                    r_rem <= w_diff[31:0];
                    r_quo <= {r_quo[30:0], 1'b1};
                end else begin
                    r_rem <= w_rem_sh[31:0];
                    r_quo <= {r_quo[30:0], 1'b0};
                end
                r_cnt <= r_cnt - 6'd1;
                if (r_cnt == 6'd1) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign done      = r_done;
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: multi-cycle MULT/MULTU, iterative DIV/DIVU
// with a sign-fixup cycle, and single-edge MTHI/MTLO writes.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_LAT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [4:0] MUL_INIT = 5'(MULT_LAT - 1);

    md_state_t   r_state;
    logic        r_busy;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_signed;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_div_zero;

    logic        w_is_div;
    logic        w_div_start;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic        w_div_done;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;
    logic [63:0] w_ax;
    logic [63:0] w_bx;
    logic [63:0] w_prod;

    assign w_is_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign w_div_start = (r_state == S_IDLE) && start && w_is_div;
    assign w_mag_a     = mag32(a, op == OP_DIV);
    assign w_mag_b     = mag32(b, op == OP_DIV);

    md_divider u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (w_div_start),
        .dividend  (w_mag_a),
        .divisor   (w_mag_b),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    assign w_q_fix = r_neg_q ? (~w_quo + 32'd1) : w_quo;
    assign w_r_fix = r_neg_r ? (~w_rem + 32'd1) : w_rem;

    // Sign-extending to 64 bits makes one unsigned multiply serve both modes
    assign w_ax   = {{32{r_signed & r_a[31]}}, r_a};
    assign w_bx   = {{32{r_signed & r_b[31]}}, r_b};
    assign w_prod = w_ax * w_bx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_signed   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                r_a      <= a;
                                r_b      <= b;
                                r_signed <= (op == OP_MULT);
                                r_cnt    <= MUL_INIT;
                                r_state  <= S_MUL;
                                r_busy   <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_neg_q    <= (op == OP_DIV) && (a[31] ^ b[31]);
                                r_neg_r    <= (op == OP_DIV) && a[31];
                                r_div_zero <= (b == 32'd0);
                                r_cnt      <= 5'd31;
                                r_state    <= S_DIV;
                                r_busy     <= 1'b1;
                            end
                            OP_MTHI: r_hi <= a;
                            OP_MTLO: r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (r_cnt == 5'd0) begin
                        r_hi    <= w_prod[63:32];
                        r_lo    <= w_prod[31:0];
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_DIV: begin
                    if (r_cnt == 5'd0) begin
                        r_state <= S_FIX;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_FIX: begin
                    if (w_div_done && !r_div_zero) begin
                        r_lo <= w_q_fix;
                        r_hi <= w_r_fix;
                    end
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: multiply/divide results, busy lengths,
// MTHI/MTLO, divide-by-zero, ignored requests and mid-operation reset.
module tb_md_unit;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests;
    int n_fail;
    int cyc;

    md_unit #(.MULT_LAT(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble operands, count busy cycles (bounded).
    // With inj set, an MTLO of 0x99 is presented on busy cycle 2.
    task automatic run_op(input logic [2:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input bit inj,
                          output int cycles);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start  = 1'b0;
        a      = 32'hDEAD_BEEF;
        b      = 32'h0BAD_F00D;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            if (inj && cycles == 2) begin
                start = 1'b1;
                op    = OP_MTLO;
                a     = 32'h99;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        op      = OP_MULT;
        a       = '0;
        b       = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, cyc);
        check("mult_cyc", cyc, 32'd5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, cyc);
        check("multu_cyc", cyc, 32'd5);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc);
        check("div_cyc", cyc, 32'd33);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        run_op(OP_DIVU, 32'd7, 32'd2, 1'b0, cyc);
        check("divu_cyc", cyc, 32'd33);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc);
        check("divov_lo", lo, 32'h8000_0000);
        check("divov_hi", hi, 32'd0);

        run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b0, cyc);
        check("divpn_lo", lo, 32'hFFFF_FFF2);
        check("divpn_hi", hi, 32'd2);

        run_op(OP_MTHI, 32'h1234_5678, 32'd0, 1'b0, cyc);
        check("mthi_cyc", cyc, 32'd0);
        check("mthi_hi", hi, 32'h1234_5678);
        run_op(OP_MTLO, 32'd9, 32'd0, 1'b0, cyc);
        check("mtlo_cyc", cyc, 32'd0);
        check("mtlo_lo", lo, 32'd9);
        check("mtlo_hi", hi, 32'h1234_5678);

        run_op(OP_MTHI, 32'hA, 32'd0, 1'b0, cyc);
        run_op(OP_MTLO, 32'hB, 32'd0, 1'b0, cyc);
        run_op(OP_DIVU, 32'd5, 32'd0, 1'b0, cyc);
        check("dz_cyc", cyc, 32'd33);
        check("dz_hi", hi, 32'hA);
        check("dz_lo", lo, 32'hB);

        run_op(3'd7, 32'h55, 32'h66, 1'b0, cyc);
        check("badop_cyc", cyc, 32'd0);
        check("badop_hi", hi, 32'hA);
        check("badop_lo", lo, 32'hB);

        run_op(OP_MULT, 32'd7, 32'hFFFF_FFFA, 1'b1, cyc);
        check("mtlo_ign_cyc", cyc, 32'd5);
        check("mtlo_ign_lo", lo, 32'hFFFF_FFD6);
        check("mtlo_ign_hi", hi, 32'hFFFF_FFFF);

        start = 1'b1;
        op    = OP_DIV;
        a     = 32'd100;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("div_mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        start = 1'b1;
        op    = OP_MULT;
        a     = 32'd5;
        b     = 32'd5;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        check("rst2_busy", {31'd0, busy}, 32'd0);
        check("rst2_hi", hi, 32'd0);
        check("rst2_lo", lo, 32'd0);
        @(posedge clk);
        #1;
        check("rst2_idle", {31'd0, busy}, 32'd0);

        run_op(OP_MULT, 32'd3, 32'd4, 1'b0, cyc);
        check("post_cyc", cyc, 32'd5);
        check("post_lo", lo, 32'd12);
        check("post_hi", hi, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
